// File: rtl/xbar_write_router_if.sv
// Write-path bundle between the upstream AXI master, the address decoder,
// the downstream slave ports and the local error responder.
interface xbar_write_router_if #(
    parameter int ID_WIDTH    = 4,
    parameter int slaves      = 2,
    parameter int order_depth = 4
);
    localparam int DEST_W = $clog2(slaves);
    localparam int CNT_W  = $clog2(order_depth) + 1;

    logic                s_awvalid;
    logic                s_awready;
    logic [ID_WIDTH-1:0] s_awid;
    logic                s_aw_hit;
    logic [DEST_W-1:0]   s_aw_dest;
    logic                m_awvalid;
    logic                m_awready;
    logic                s_wvalid;
    logic                s_wready;
    logic                s_wlast;
    logic                m_wvalid;
    logic                m_wready;
    logic [DEST_W-1:0]   w_dest;
    logic                err_bvalid;
    logic                err_bready;
    logic [ID_WIDTH-1:0] err_bid;
    logic [1:0]          err_bresp;
    logic [CNT_W-1:0]    order_count;

    modport slave (
        input  s_awvalid, s_awid, s_aw_hit, s_aw_dest, m_awready,
               s_wvalid, s_wlast, m_wready, err_bready,
        output s_awready, m_awvalid, s_wready, m_wvalid, w_dest,
               err_bvalid, err_bid, err_bresp, order_count
    );

    modport master (
        output s_awvalid, s_awid, s_aw_hit, s_aw_dest, m_awready,
               s_wvalid, s_wlast, m_wready, err_bready,
        input  s_awready, m_awvalid, s_wready, m_wvalid, w_dest,
               err_bvalid, err_bid, err_bresp, order_count
    );
endinterface

// File: rtl/xbar_write_router.sv
// Crossbar write router: orders W bursts behind accepted AWs, steers them to the
// decoded slave, and sinks unmapped bursts with a local DECERR response.
module xbar_write_router #(
    parameter int ID_WIDTH    = 4,
    parameter int slaves      = 2,
    parameter int order_depth = 4
) (
    input logic                 ACLK,
    input logic                 ARESETn,
    xbar_write_router_if.slave  bus
);
    localparam int DEST_W = $clog2(slaves);
    localparam int PTR_W  = $clog2(order_depth);
    localparam int CNT_W  = PTR_W + 1;

    logic                err_q  [order_depth];
    logic [DEST_W-1:0]   dest_q [order_depth];
    logic [ID_WIDTH-1:0] id_q   [order_depth];

    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                full, empty, push, pop;
    logic                aw_ready, w_ready, w_valid_m;
    logic [DEST_W-1:0]   w_dest_c;
    logic                head_err;
    logic [DEST_W-1:0]   head_dest;
    logic [ID_WIDTH-1:0] head_id;

    logic                err_bvalid_q;
    logic [ID_WIDTH-1:0] err_bid_q;
    logic [1:0]          err_bresp_q;

    assign full      = (count == CNT_W'(order_depth));
    assign empty     = (count == '0);
    assign head_err  = err_q[rd_ptr];
    assign head_dest = dest_q[rd_ptr];
    assign head_id   = id_q[rd_ptr];

    // Handshake outputs are forced low while reset is held so nothing is
    // accepted or forwarded in the reset window.
    always_comb begin
        aw_ready  = ARESETn & ~full & (~bus.s_aw_hit | bus.m_awready);
        w_ready   = 1'b0;
        w_valid_m = 1'b0;
        w_dest_c  = '0;
        if (!empty) begin
            w_dest_c = head_dest;
            if (ARESETn) begin
                if (!head_err) begin
                    w_valid_m = bus.s_wvalid;
                    w_ready   = bus.m_wready;
                end else begin
                    // Error bursts are swallowed; the last beat waits for the
                    // single response slot to be free.
                    w_ready = bus.s_wlast ? ~err_bvalid_q : 1'b1;
                end
            end
        end
    end

    assign push = bus.s_awvalid & aw_ready;
    assign pop  = bus.s_wvalid & w_ready & bus.s_wlast;

    assign bus.s_awready   = aw_ready;
    assign bus.m_awvalid   = ARESETn & bus.s_awvalid & bus.s_aw_hit & ~full;
    assign bus.s_wready    = w_ready;
    assign bus.m_wvalid    = w_valid_m;
    assign bus.w_dest      = w_dest_c;
    assign bus.err_bvalid  = err_bvalid_q;
    assign bus.err_bid     = err_bid_q;
    assign bus.err_bresp   = err_bresp_q;
    assign bus.order_count = count;

    always_ff @(posedge ACLK) begin
        if (push) begin
            err_q[wr_ptr]  <= ~bus.s_aw_hit;
            dest_q[wr_ptr] <= bus.s_aw_dest;
            id_q[wr_ptr]   <= bus.s_awid;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_bvalid_q <= 1'b0;
            err_bid_q    <= '0;
            err_bresp_q  <= 2'b00;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (pop && head_err) begin
                err_bvalid_q <= 1'b1;
                err_bid_q    <= head_id;
                err_bresp_q  <= 2'b11;
            end else if (err_bvalid_q && bus.err_bready) begin
                err_bvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_xbar_write_router.sv
// Directed cycle-by-cycle vectors for xbar_write_router: inputs are applied after
// the falling edge and all outputs are compared just before the next rising edge.
module tb_xbar_write_router;
    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    xbar_write_router_if #(.ID_WIDTH(4), .slaves(2), .order_depth(4)) bus ();

    xbar_write_router #(.ID_WIDTH(4), .slaves(2), .order_depth(4)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    typedef struct packed {
        logic       rstn;
        logic       awv;
        logic [3:0] awid;
        logic       hit;
        logic       dst;
        logic       mawr;
        logic       wv;
        logic       wl;
        logic       mwr;
        logic       br;
    } in_t;

    typedef struct packed {
        logic       aw;
        logic       mawv;
        logic       wr;
        logic       mwv;
        logic       wd;
        logic       bv;
        logic [3:0] bid;
        logic [1:0] bresp;
        logic [2:0] cnt;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t tbl[$];
    int   tests  = 0;
    int   failed = 0;

    function automatic in_t vi(input logic rstn, awv, input logic [3:0] awid,
                               input logic hit, dst, mawr, wv, wl, mwr, br);
        in_t r;
        r.rstn = rstn; r.awv = awv; r.awid = awid; r.hit = hit; r.dst = dst;
        r.mawr = mawr; r.wv = wv; r.wl = wl; r.mwr = mwr; r.br = br;
        return r;
    endfunction

    function automatic out_t vo(input logic aw, mawv, wr, mwv, wd, bv,
                                input logic [3:0] bid, input logic [1:0] bresp,
                                input logic [2:0] cnt);
        out_t r;
        r.aw = aw; r.mawv = mawv; r.wr = wr; r.mwv = mwv; r.wd = wd;
        r.bv = bv; r.bid = bid; r.bresp = bresp; r.cnt = cnt;
        return r;
    endfunction

    function automatic void add(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        tbl.push_back(v);
    endfunction

    task automatic drive(input in_t i);
        ARESETn        = i.rstn;
        bus.s_awvalid  = i.awv;
        bus.s_awid     = i.awid;
        bus.s_aw_hit   = i.hit;
        bus.s_aw_dest  = i.dst;
        bus.m_awready  = i.mawr;
        bus.s_wvalid   = i.wv;
        bus.s_wlast    = i.wl;
        bus.m_wready   = i.mwr;
        bus.err_bready = i.br;
    endtask

    function automatic out_t sample();
        out_t r;
        r.aw = bus.s_awready; r.mawv = bus.m_awvalid; r.wr = bus.s_wready;
        r.mwv = bus.m_wvalid; r.wd = bus.w_dest; r.bv = bus.err_bvalid;
        r.bid = bus.err_bid; r.bresp = bus.err_bresp; r.cnt = bus.order_count;
        return r;
    endfunction

    task automatic step(input in_t i, input out_t e, input string tag, input int k);
        out_t act;
        @(negedge ACLK);
        drive(i);
        #1;
        act = sample();
        tests++;
        if (act !== e) begin
            failed++;
            $display("FAIL %s[%0d]: got aw=%b mawv=%b wr=%b mwv=%b wd=%b bv=%b bid=%0d bresp=%b cnt=%0d, expected aw=%b mawv=%b wr=%b mwv=%b wd=%b bv=%b bid=%0d bresp=%b cnt=%0d",
                     tag, k, act.aw, act.mawv, act.wr, act.mwv, act.wd, act.bv, act.bid,
                     act.bresp, act.cnt, e.aw, e.mawv, e.wr, e.mwv, e.wd, e.bv, e.bid,
                     e.bresp, e.cnt);
        end
    endtask

    initial begin
        drive(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge ACLK);

        // Reset window with every input asserted: nothing may handshake
        add(vi(0,1,3,1,1,1,1,1,1,1), vo(0,0,0,0,0,0,0,2'd0,0));
        // Mapped AW id=3 -> dest 1, early W stalled, 4-beat burst with one stall
        add(vi(1,1,3,1,1,1,1,0,1,0), vo(1,1,0,0,0,0,0,2'd0,0));
        add(vi(1,0,0,0,0,0,1,0,1,0), vo(1,0,1,1,1,0,0,2'd0,1));
        add(vi(1,0,0,0,0,0,1,0,0,0), vo(1,0,0,1,1,0,0,2'd0,1));
        add(vi(1,0,0,0,0,0,1,0,1,0), vo(1,0,1,1,1,0,0,2'd0,1));
        add(vi(1,0,0,0,0,0,1,0,1,0), vo(1,0,1,1,1,0,0,2'd0,1));
        add(vi(1,0,0,0,0,0,1,1,1,0), vo(1,0,1,1,1,0,0,2'd0,1));
        add(vi(1,0,0,0,0,0,0,0,0,0), vo(1,0,0,0,0,0,0,2'd0,0));
        // Fill the order FIFO, fifth AW blocked, one WLAST frees one slot, drain
        add(vi(1,1,1,1,0,1,0,0,0,0), vo(1,1,0,0,0,0,0,2'd0,0));
        add(vi(1,1,2,1,0,1,0,0,0,0), vo(1,1,0,0,0,0,0,2'd0,1));
        add(vi(1,1,3,1,0,1,0,0,0,0), vo(1,1,0,0,0,0,0,2'd0,2));
        add(vi(1,1,4,1,0,1,0,0,0,0), vo(1,1,0,0,0,0,0,2'd0,3));
        add(vi(1,1,5,1,0,1,0,0,0,0), vo(0,0,0,0,0,0,0,2'd0,4));
        add(vi(1,1,5,1,0,1,1,1,1,0), vo(0,0,1,1,0,0,0,2'd0,4));
        add(vi(1,1,5,1,0,1,0,0,0,0), vo(1,1,0,0,0,0,0,2'd0,3));
        add(vi(1,0,0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,2'd0,4));
        add(vi(1,0,0,0,0,0,1,1,1,0), vo(0,0,1,1,0,0,0,2'd0,4));
        add(vi(1,0,0,0,0,0,1,1,1,0), vo(1,0,1,1,0,0,0,2'd0,3));
        add(vi(1,0,0,0,0,0,1,1,1,0), vo(1,0,1,1,0,0,0,2'd0,2));
        add(vi(1,0,0,0,0,0,1,1,1,0), vo(1,0,1,1,0,0,0,2'd0,1));
        add(vi(1,0,0,0,0,0,0,0,0,0), vo(1,0,0,0,0,0,0,2'd0,0));
        // Dest 0 burst of 2 then dest 1 burst of 3; AW backpressure; push+pop together
        add(vi(1,1,6,1,0,1,0,0,0,0), vo(1,1,0,0,0,0,0,2'd0,0));
        add(vi(1,1,7,1,1,1,1,0,1,0), vo(1,1,1,1,0,0,0,2'd0,1));
        add(vi(1,1,8,1,1,0,1,1,1,0), vo(0,1,1,1,0,0,0,2'd0,2));
        add(vi(1,0,0,0,0,0,1,0,1,0), vo(1,0,1,1,1,0,0,2'd0,1));
        add(vi(1,0,0,0,0,0,1,0,1,0), vo(1,0,1,1,1,0,0,2'd0,1));
        add(vi(1,1,9,0,0,0,1,1,1,0), vo(1,0,1,1,1,0,0,2'd0,1));
        add(vi(1,0,0,0,0,0,0,0,0,0), vo(1,0,1,0,0,0,0,2'd0,1));
        add(vi(1,0,0,0,0,0,1,1,0,0), vo(1,0,1,0,0,0,0,2'd0,1));
        add(vi(1,0,0,0,0,0,0,0,0,1), vo(1,0,0,0,0,1,9,2'd3,0));
        add(vi(1,0,0,0,0,0,0,0,0,0), vo(1,0,0,0,0,0,9,2'd3,0));
        // Unmapped AW id=5, 2-beat W sunk, DECERR held until err_bready
        add(vi(1,1,5,0,0,0,0,0,0,0), vo(1,0,0,0,0,0,9,2'd3,0));
        add(vi(1,0,0,0,0,0,1,0,0,0), vo(1,0,1,0,0,0,9,2'd3,1));
        add(vi(1,0,0,0,0,0,1,1,0,0), vo(1,0,1,0,0,0,9,2'd3,1));
        add(vi(1,0,0,0,0,0,0,0,0,0), vo(1,0,0,0,0,1,5,2'd3,0));
        add(vi(1,0,0,0,0,0,0,0,0,0), vo(1,0,0,0,0,1,5,2'd3,0));
        add(vi(1,0,0,0,0,0,0,0,0,1), vo(1,0,0,0,0,1,5,2'd3,0));
        add(vi(1,0,0,0,0,0,0,0,0,0), vo(1,0,0,0,0,0,5,2'd3,0));

        foreach (tbl[k]) step(tbl[k].i, tbl[k].o, "vec", k);

        // Two back-to-back error bursts: second last beat waits for the first response
        step(vi(1,1,10,0,0,0,0,0,0,0), vo(1,0,0,0,0,0,5,2'd3,0), "errpair", 0);
        step(vi(1,1,11,0,1,0,0,0,0,0), vo(1,0,1,0,0,0,5,2'd3,1), "errpair", 1);
        step(vi(1,0,0,0,0,0,1,1,0,0),  vo(1,0,1,0,0,0,5,2'd3,2), "errpair", 2);
        step(vi(1,0,0,0,0,0,1,1,0,0),  vo(1,0,0,0,1,1,10,2'd3,1), "errpair", 3);
        step(vi(1,0,0,0,0,0,1,1,0,0),  vo(1,0,0,0,1,1,10,2'd3,1), "errpair", 4);
        step(vi(1,0,0,0,0,0,1,1,0,1),  vo(1,0,0,0,1,1,10,2'd3,1), "errpair", 5);
        step(vi(1,0,0,0,0,0,1,1,0,0),  vo(1,0,1,0,1,0,10,2'd3,1), "errpair", 6);
        step(vi(1,0,0,0,0,0,0,0,0,0),  vo(1,0,0,0,0,1,11,2'd3,0), "errpair", 7);
        step(vi(1,0,0,0,0,0,0,0,0,0),  vo(1,0,0,0,0,1,11,2'd3,0), "errpair", 8);

        // Reset mid-burst with two entries queued and a response still pending
        step(vi(1,1,1,1,1,1,0,0,0,0), vo(1,1,0,0,0,1,11,2'd3,0), "midrst", 0);
        step(vi(1,1,2,0,0,0,1,0,1,0), vo(1,0,1,1,1,1,11,2'd3,1), "midrst", 1);
        step(vi(1,0,0,0,0,0,1,0,1,0), vo(1,0,1,1,1,1,11,2'd3,2), "midrst", 2);
        step(vi(0,1,6,1,0,1,1,0,1,0), vo(0,0,0,0,1,1,11,2'd3,2), "midrst", 3);
        step(vi(0,1,6,1,0,1,1,0,1,0), vo(0,0,0,0,0,0,0,2'd0,0),  "midrst", 4);
        step(vi(1,0,0,0,0,0,1,1,1,0), vo(1,0,0,0,0,0,0,2'd0,0),  "midrst", 5);
        step(vi(1,0,0,0,0,0,0,0,0,0), vo(1,0,0,0,0,0,0,2'd0,0),  "midrst", 6);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/xbar_write_router.md
XBAR_WRITE_ROUTER -- requirements
Module: xbar_write_router

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AXI transaction ID width.
REQ-002 SHALL have parameter slaves, default 2, number of downstream slave ports, at least 2.
REQ-003 SHALL have parameter order_depth, default 4, number of outstanding write-order entries, a power of two and at least 2.
REQ-004 SHALL have port ACLK, input, 1 bit, clock; all state updates on its rising edge.
REQ-005 SHALL have port ARESETn, input, 1 bit, synchronous active-low reset.
REQ-006 SHALL have ports s_awvalid (in, 1), s_awready (out, 1), s_awid (in, ID_WIDTH): upstream AW handshake and ID.
REQ-007 SHALL have ports s_aw_hit (in, 1) and s_aw_dest (in, $clog2(slaves)): decoder result for the current AW; hit=0 means unmapped address.
REQ-008 SHALL have ports m_awvalid (out, 1) and m_awready (in, 1): downstream AW handshake toward slave s_aw_dest.
REQ-009 SHALL have ports s_wvalid (in, 1), s_wready (out, 1), s_wlast (in, 1): upstream W handshake.
REQ-010 SHALL have ports m_wvalid (out, 1), m_wready (in, 1), w_dest (out, $clog2(slaves)): downstream W handshake and target slave.
REQ-011 SHALL have ports err_bvalid (out, 1), err_bready (in, 1), err_bid (out, ID_WIDTH), err_bresp (out, 2): locally generated error response.
REQ-012 SHALL have port order_count (out, $clog2(order_depth)+1): number of occupied order entries.

Function
REQ-013 SHALL keep an order FIFO of entries {err, dest, id}; each accepted AW pushes one entry.
REQ-014 SHALL drive s_awready = ~full & (~s_aw_hit | m_awready).
REQ-015 SHALL drive m_awvalid = s_awvalid & s_aw_hit & ~full; AW with hit=0 is never forwarded.
REQ-016 SHALL push entry {~s_aw_hit, s_aw_dest, s_awid} on s_awvalid & s_awready.
REQ-017 SHALL treat the FIFO head as the owner of the W channel; W bursts are never interleaved and follow AW acceptance order.
REQ-018 SHALL drive s_wready=0, m_wvalid=0 when the FIFO is empty (W before AW is stalled, not dropped).
REQ-019 For a non-error head: m_wvalid = s_wvalid, s_wready = m_wready, w_dest = head.dest, all combinational.
REQ-020 For an error head: m_wvalid=0; s_wready=1 for non-last beats (data discarded); for the last beat, s_wready = ~err_bvalid.
REQ-021 SHALL pop the head on an upstream W handshake with s_wlast=1.
REQ-022 On the error-head last-beat handshake, SHALL set err_bvalid=1, err_bid=head.id, err_bresp=2'b11 (DECERR) on the next cycle.
REQ-023 SHALL hold err_bvalid/err_bid/err_bresp stable until err_bready=1, then clear err_bvalid the next cycle.
REQ-024 On same-cycle push and pop, order_count SHALL be unchanged and both operations take effect.
REQ-025 On push to a full FIFO: impossible by REQ-014. On pop of an empty FIFO: impossible by REQ-018.
REQ-026 Read/write pointers SHALL wrap modulo order_depth; order_count SHALL saturate at neither end beyond 0..order_depth.
REQ-027 w_dest SHALL equal head.dest when non-empty, 0 when empty.
REQ-028 The latency from AW acceptance to W eligibility SHALL be 1 cycle (entry visible at head next cycle).

Reset
REQ-029 When ARESETn=0 at a clock edge, SHALL clear pointers and order_count to 0, err_bvalid to 0, err_bid to 0, err_bresp to 0.
REQ-030 Reset mid-burst SHALL discard all outstanding entries and any pending error response; no stale W routing after reset.
REQ-031 During reset, s_awready, s_wready, m_awvalid, m_wvalid SHALL be 0 on the cycle following the reset edge until ARESETn=1.

Verification
REQ-032 AW id=3 hit dest=1, then 4-beat W, m_wready=1 -> m_wvalid 4 cycles, w_dest=1, order_count 1->0 after WLAST.
REQ-033 AW id=5 hit=0, then 2-beat W -> m_awvalid never 1, W consumed, err_bvalid=1 with err_bid=5, err_bresp=2'b11 until err_bready.
REQ-034 Four AWs back-to-back (order_depth=4), no W -> order_count=4, s_awready=0 on fifth AW; one WLAST frees one slot.
REQ-035 AW to dest 0 then dest 1, W bursts of len 2 and 3 -> first 2 beats to w_dest=0, next 3 to w_dest=1, no interleave.
REQ-036 Two error bursts, err_bready=0 -> second last beat stalled (s_wready=0) until first err response accepted.
REQ-037 ARESETn=0 while order_count=2 mid-burst -> order_count=0, err_bvalid=0, s_wready=0 next cycle.
